// File: rtl/roic_frame_aligner.sv
// roic_frame_aligner
// Per-lane ROIC line aligner. Hunts for the line header word, confirms it over
// LOCK_CNT consecutive lines, then forwards the NUM_CH channel words of every
// line with valid, channel index and line start/end strobes. While locked, a
// missing header is bridged by the free-running slot counter (flywheel) until
// UNLOCK_CNT consecutive headers have been missed.
//
// Build option: define ROIC_ALIGN_STATS_EN to build the sync_err_cnt and
// lock_loss_cnt statistics counters; otherwise both ports read constant 0.

module roic_frame_aligner #(
  parameter int                   WORD_SIZE  = 24,
  parameter int                   NUM_CH     = 256,
  parameter logic [WORD_SIZE-1:0] SYNC_WORD  = 24'hFFF000,
  parameter int                   LOCK_CNT   = 4,
  parameter int                   UNLOCK_CNT = 2,
  parameter int                   CH_W       = $clog2(NUM_CH)
) (
  input  logic                 fclk_out,
  input  logic                 rst_n,
  input  logic                 align_en,
  input  logic                 resync,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic [CH_W-1:0]      ch_idx,
  output logic                 line_start,
  output logic                 line_end,
  output logic                 locked,
  output logic [15:0]          sync_err_cnt,
  output logic [7:0]           lock_loss_cnt
);

  // Slot 0 is the header, slots 1..NUM_CH carry channel words.
  localparam int SLOT_W  = $clog2(NUM_CH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [SLOT_W-1:0]  SLOT_HDR   = SLOT_W'(0);
  localparam logic [SLOT_W-1:0]  SLOT_FIRST = SLOT_W'(1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(NUM_CH);
  // Counter value that, with one more event, reaches the threshold.
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_CNT - 1);
  localparam bit                 LOCK_ON_FIRST = (LOCK_CNT == 1);

  logic [1:0]         state_r;
  logic [SLOT_W-1:0]  slot_r;
  logic [MATCH_W-1:0] match_cnt_r;
  logic [MISS_W-1:0]  miss_cnt_r;

  logic [1:0]         state_s;
  logic [SLOT_W-1:0]  slot_s;
  logic [SLOT_W-1:0]  slot_next_s;
  logic [MATCH_W-1:0] match_cnt_s;
  logic [MISS_W-1:0]  miss_cnt_s;
  logic               locked_s;
  logic               valid_s;
  logic               start_s;
  logic               end_s;
  logic               load_s;
  logic               hdr_match_s;
  logic               force_hunt_s;

  assign hdr_match_s  = (data_in == SYNC_WORD);
  assign force_hunt_s = resync | ~align_en;
  assign slot_next_s  = (slot_r == SLOT_LAST) ? SLOT_HDR : (slot_r + SLOT_W'(1));

  // Next-state, slot/lock bookkeeping and output strobes for the current word.
  always_comb begin
    state_s     = state_r;
    slot_s      = slot_r;
    match_cnt_s = match_cnt_r;
    miss_cnt_s  = miss_cnt_r;
    locked_s    = locked;
    valid_s     = 1'b0;
    start_s     = 1'b0;
    end_s       = 1'b0;
    load_s      = 1'b0;

    if (force_hunt_s) begin
      // Resync / disable beats any header seen on the same word.
      state_s     = ST_HUNT;
      slot_s      = SLOT_HDR;
      match_cnt_s = MATCH_W'(0);
      miss_cnt_s  = MISS_W'(0);
      locked_s    = 1'b0;
    end else begin
      case (state_r)
        ST_HUNT: begin
          if (hdr_match_s) begin
            slot_s     = SLOT_FIRST;
            miss_cnt_s = MISS_W'(0);
            if (LOCK_ON_FIRST) begin
              state_s     = ST_LOCKED;
              match_cnt_s = MATCH_W'(0);
              locked_s    = 1'b1;
            end else begin
              state_s     = ST_CONFIRM;
              match_cnt_s = MATCH_W'(1);
            end
          end else begin
            slot_s      = SLOT_HDR;
            match_cnt_s = MATCH_W'(0);
          end
        end

        ST_CONFIRM: begin
          if (slot_r == SLOT_HDR) begin
            if (hdr_match_s) begin
              slot_s = SLOT_FIRST;
              if (match_cnt_r == MATCH_LAST) begin
                state_s     = ST_LOCKED;
                match_cnt_s = MATCH_W'(0);
                miss_cnt_s  = MISS_W'(0);
                locked_s    = 1'b1;
              end else begin
                match_cnt_s = match_cnt_r + MATCH_W'(1);
              end
            end else begin
              state_s     = ST_HUNT;
              slot_s      = SLOT_HDR;
              match_cnt_s = MATCH_W'(0);
            end
          end else begin
            // Data slots are only counted, never forwarded, until lock.
            slot_s = slot_next_s;
          end
        end

        ST_LOCKED: begin
          if (slot_r == SLOT_HDR) begin
            if (hdr_match_s) begin
              slot_s     = SLOT_FIRST;
              miss_cnt_s = MISS_W'(0);
            end else if (miss_cnt_r == MISS_LAST) begin
              state_s    = ST_HUNT;
              slot_s     = SLOT_HDR;
              miss_cnt_s = MISS_W'(0);
              locked_s   = 1'b0;
            end else begin
              // Flywheel: keep the line timing and trust the slot counter.
              slot_s     = SLOT_FIRST;
              miss_cnt_s = miss_cnt_r + MISS_W'(1);
            end
          end else begin
            valid_s = 1'b1;
            load_s  = 1'b1;
            start_s = (slot_r == SLOT_FIRST);
            end_s   = (slot_r == SLOT_LAST);
            slot_s  = slot_next_s;
          end
        end

        default: begin
          state_s     = ST_HUNT;
          slot_s      = SLOT_HDR;
          match_cnt_s = MATCH_W'(0);
          miss_cnt_s  = MISS_W'(0);
          locked_s    = 1'b0;
        end
      endcase
    end
  end

  // Alignment state, counters and registered status/strobe outputs.
  always_ff @(posedge fclk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_HUNT;
      slot_r      <= SLOT_HDR;
      match_cnt_r <= MATCH_W'(0);
      miss_cnt_r  <= MISS_W'(0);
      locked      <= 1'b0;
      data_valid  <= 1'b0;
      line_start  <= 1'b0;
      line_end    <= 1'b0;
    end else begin
      state_r     <= state_s;
      slot_r      <= slot_s;
      match_cnt_r <= match_cnt_s;
      miss_cnt_r  <= miss_cnt_s;
      locked      <= locked_s;
      data_valid  <= valid_s;
      line_start  <= start_s;
      line_end    <= end_s;
    end
  end

  // Data word and channel index; held while no channel word is presented.
  always_ff @(posedge fclk_out or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= {WORD_SIZE{1'b0}};
      ch_idx   <= CH_W'(0);
    end else if (load_s) begin
      data_out <= data_in;
      ch_idx   <= CH_W'(slot_r - SLOT_W'(1));
    end else begin
      data_out <= data_out;
      ch_idx   <= ch_idx;
    end
  end

`ifdef ROIC_ALIGN_STATS_EN
  logic miss_evt_s;
  logic loss_evt_s;

  assign miss_evt_s = ~force_hunt_s & (state_r == ST_LOCKED) &
                      (slot_r == SLOT_HDR) & ~hdr_match_s;
  assign loss_evt_s = (state_r == ST_LOCKED) & (state_s == ST_HUNT);

  // Saturating count of headers missed while locked.
  always_ff @(posedge fclk_out or negedge rst_n) begin
    if (!rst_n) begin
      sync_err_cnt <= 16'd0;
    end else if (miss_evt_s && (sync_err_cnt != 16'hFFFF)) begin
      sync_err_cnt <= sync_err_cnt + 16'd1;
    end else begin
      sync_err_cnt <= sync_err_cnt;
    end
  end

  // Saturating count of exits from LOCKED, whatever the cause.
  always_ff @(posedge fclk_out or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt <= 8'd0;
    end else if (loss_evt_s && (lock_loss_cnt != 8'hFF)) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end else begin
      lock_loss_cnt <= lock_loss_cnt;
    end
  end
`else
  assign sync_err_cnt  = 16'd0;
  assign lock_loss_cnt = 8'd0;
`endif

endmodule
